// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and requester ids for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam logic MID_IF  = 1'b0;
  localparam logic MID_LSU = 1'b1;

endpackage

// File: rtl/arb_pick2.sv
// rtl/arb_pick2.sv - two-way winner select; MEM_ARB_RR_EN selects round-robin over fixed priority
module arb_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_winner_i,
  output logic       win_o,
  output logic       any_o
);

  assign any_o = |req_i;

`ifdef MEM_ARB_RR_EN
  // On contention the id that did not win last time goes first.
  always_comb begin
    win_o = MID_IF;
    if (&req_i)        win_o = ~last_winner_i;
    else if (req_i[1]) win_o = MID_LSU;
  end
`else
  logic unused_last_winner;
  assign unused_last_winner = last_winner_i;

  assign win_o = req_i[1] ? MID_LSU : MID_IF;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-outstanding memory port between IF (M0) and LSU (M1); MEM_ARB_RR_EN enables round-robin
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic                m0_we,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_done,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic                m1_we,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_done,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_req,
  output logic [ADDR_W-1:0]   s_addr,
  output logic                s_we,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_ready,
  input  logic                s_rvalid,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic                sel
);

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q, last_d;
  logic   win, any;
  logic   done;

  arb_pick2 u_pick (
    .req_i         ({m1_req, m0_req}),
    .last_winner_i (last_q),
    .win_o         (win),
    .any_o         (any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= MID_IF;
      last_q  <= MID_LSU;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    s_req   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (any) begin
          owner_d = win;
          last_d  = win;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        s_req = 1'b1;
        if (s_ready) begin
          // A response in the accept cycle completes without visiting WAIT.
          if (s_rvalid) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (s_rvalid) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sel     = owner_q;
  assign s_addr  = owner_q ? m1_addr  : m0_addr;
  assign s_we    = owner_q ? m1_we    : m0_we;
  assign s_wdata = owner_q ? m1_wdata : m0_wdata;
  assign s_wstrb = owner_q ? m1_wstrb : m0_wstrb;

  assign m0_done  = done & (owner_q == MID_IF);
  assign m1_done  = done & (owner_q == MID_LSU);
  assign m0_rdata = m0_done ? s_rdata : '0;
  assign m1_rdata = m1_done ? s_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_done, m1_done;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_we, s_ready, s_rvalid, sel;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_done(m0_done), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_done(m1_done), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_addr(s_addr), .s_we(s_we), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .sel(sel)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic at_sample();
    @(negedge clk);
  endtask

  // Runs one zero-wait transaction starting in IDLE with requests already driven.
  task automatic run_xact(input string tag, input logic exp_id,
                          input logic [31:0] exp_addr, input logic [31:0] rd);
    at_sample();
    chk({tag, "_idle_sreq"}, s_req, 1'b0);
    next_cycle();
    s_ready = 1'b1;
    at_sample();
    chk({tag, "_issue_sreq"}, s_req, 1'b1);
    chk({tag, "_issue_sel"}, sel, exp_id);
    chk({tag, "_issue_addr"}, s_addr, exp_addr);
    next_cycle();
    s_ready  = 1'b0;
    s_rvalid = 1'b1;
    s_rdata  = rd;
    at_sample();
    chk({tag, "_wait_sreq"}, s_req, 1'b0);
    chk({tag, "_m0_done"}, m0_done, exp_id == 1'b0);
    chk({tag, "_m1_done"}, m1_done, exp_id == 1'b1);
    chk({tag, "_m0_rdata"}, m0_rdata, exp_id == 1'b0 ? rd : 32'h0);
    chk({tag, "_m1_rdata"}, m1_rdata, exp_id == 1'b1 ? rd : 32'h0);
    next_cycle();
    s_rvalid = 1'b0;
    s_rdata  = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 0; m0_addr = 0; m0_we = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_req = 0; m1_addr = 0; m1_we = 0; m1_wdata = 0; m1_wstrb = 0;
    s_ready = 0; s_rvalid = 0; s_rdata = 0;
    next_cycle();
    next_cycle();
    at_sample();
    chk("rst_sreq", s_req, 1'b0);
    chk("rst_sel", sel, 1'b0);
    chk("rst_dones", {m0_done, m1_done}, 2'b00);
    next_cycle();
    rst = 1'b0;

    // Single read from M0.
    m0_req = 1; m0_addr = 32'h100; m0_we = 0;
    run_xact("rd0", 1'b0, 32'h100, 32'hDEADBEEF);
    m0_req = 0;
    at_sample();
    chk("rd0_after_done", {m0_done, m1_done, s_req}, 3'b000);
    chk("rd0_after_rdata", m0_rdata, 32'h0);

    // M1 write with three cycles of backpressure.
    m1_req = 1; m1_addr = 32'h200; m1_we = 1; m1_wdata = 32'hA5A5A5A5; m1_wstrb = 4'b0011;
    m0_addr = 32'h999; m0_wdata = 32'h11111111; m0_wstrb = 4'b1111;
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      s_ready = (i == 3);
      at_sample();
      chk($sformatf("bp_sreq%0d", i), s_req, 1'b1);
      chk($sformatf("bp_pay%0d", i), {s_addr, s_we, s_wdata, s_wstrb, sel},
          {32'h200, 1'b1, 32'hA5A5A5A5, 4'b0011, 1'b1});
      chk($sformatf("bp_nodone%0d", i), {m0_done, m1_done}, 2'b00);
      next_cycle();
    end
    s_ready = 0;
    at_sample();
    chk("bp_wait_sreq", s_req, 1'b0);
    chk("bp_wait_nodone", {m0_done, m1_done}, 2'b00);
    next_cycle();
    s_rvalid = 1;
    at_sample();
    chk("bp_done", {m0_done, m1_done}, 2'b01);
    next_cycle();
    s_rvalid = 0; m1_req = 0; m1_we = 0;

    // Same-cycle accept and response.
    m0_req = 1; m0_addr = 32'h300; m0_we = 0;
    next_cycle();
    s_ready = 1; s_rvalid = 1; s_rdata = 32'h12345678;
    at_sample();
    chk("sc_done", {m0_done, m1_done}, 2'b10);
    chk("sc_rdata", m0_rdata, 32'h12345678);
    next_cycle();
    m0_req = 0; s_ready = 0;
    at_sample();
    chk("sc_idle_rvalid_nodone", {m0_done, m1_done, s_req}, 3'b000);
    next_cycle();
    s_rvalid = 0; s_rdata = 0;
    at_sample();
    chk("sc_still_idle", s_req, 1'b0);

    // Reset asserted mid-WAIT, then a late response must be ignored.
    m1_req = 1; m1_addr = 32'h400;
    next_cycle();
    s_ready = 1;
    next_cycle();
    s_ready = 0;
    at_sample();
    chk("rw_in_wait_sel", sel, 1'b1);
    next_cycle();
    rst = 1;
    next_cycle();
    rst = 0; m1_req = 0;
    at_sample();
    chk("rw_sreq", s_req, 1'b0);
    chk("rw_sel", sel, 1'b0);
    chk("rw_dones", {m0_done, m1_done}, 2'b00);
    s_rvalid = 1; s_rdata = 32'hBAD0BAD0;
    #1;
    chk("rw_late_rvalid", {m0_done, m1_done}, 2'b00);
    next_cycle();
    s_rvalid = 0; s_rdata = 0;
    at_sample();
    chk("rw_late_idle", {m0_done, m1_done, s_req}, 3'b000);

    // Contention with both requesters held high.
    do_reset();
    m0_req = 1; m0_addr = 32'hA0; m0_we = 0;
    m1_req = 1; m1_addr = 32'hB0; m1_we = 0;
`ifdef MEM_ARB_RR_EN
    run_xact("rr0", 1'b0, 32'hA0, 32'h0000_0A01);
    run_xact("rr1", 1'b1, 32'hB0, 32'h0000_0B02);
    run_xact("rr2", 1'b0, 32'hA0, 32'h0000_0A03);
    run_xact("rr3", 1'b1, 32'hB0, 32'h0000_0B04);
`else
    run_xact("fx0", 1'b1, 32'hB0, 32'h0000_0B01);
    run_xact("fx1", 1'b1, 32'hB0, 32'h0000_0B02);
    run_xact("fx2", 1'b1, 32'hB0, 32'h0000_0B03);
`endif
    m0_req = 0; m1_req = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
